muldiv_unit: RTL and testbench

- Iterative integer multiply/divide unit implementing the RISC-V M-extension ops, parametrised in operand width.
- Sits beside the ALU in the execute path. The datapath issues an op with a start pulse, stalls on busy, and writes result to the register file on done.
- Computes one bit per cycle with a shared shift/add-subtract engine, not a combinational array.

---
 rtl/muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RISC-V M-extension multiply/divide unit. One bit of work per clock
// on a shared (WIDTH+1)-bit adder: shift-add for multiplies, restoring
// subtraction for divides. Signed operands are turned into magnitudes at
// issue, and the sign is reapplied in a single finishing cycle. Divide-by-zero
// and the signed-overflow divide skip the iterative phase entirely.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      issue request, taken only when busy is low
//   op         funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU (0..7)
//   operand_a  rs1 (multiplicand / dividend)
//   operand_b  rs2 (multiplier / divisor)
//   busy       high while an operation is in flight
//   done       one-cycle pulse, result valid in that cycle
//   result     registered result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int OP_BITS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OP_BITS-1:0] op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]     ZERO_W1  = {(WIDTH+1){1'b0}};
    localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Two's-complement negate helpers for a result field and a full product.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_2W;
    endfunction

    state_t state_r, state_s;

    logic [2:0]       op_r, op_s;          // latched funct3
    logic [WIDTH-1:0] opnd_r, opnd_s;      // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0] acc_hi_r, acc_hi_s;  // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_r, acc_lo_s;  // multiplier->product low / dividend->quotient
    logic [CW-1:0]    count_r, count_s;
    logic             neg_r, neg_s;        // result field must be negated at FIN
    logic             fast_r, fast_s;      // acc_lo_r already holds the final answer
    logic [WIDTH-1:0] result_r, result_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;

    // Issue-side decode of the incoming request.
    logic [2:0]       op_in_s;
    logic             a_signed_s, b_signed_s;
    logic             sa_s, sb_s, neg_in_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic             div_zero_s, div_ovf_s;
    logic [WIDTH-1:0] fast_val_s;

    // Shared engine adder and finishing-cycle field selection.
    logic [WIDTH:0]     add_a_s, add_b_s, sum_s;
    logic               add_c_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s, fin_val_s;

    // Decode the request: operand signedness, magnitudes, result sign, fast paths.
    always_comb begin
        op_in_s    = op[2:0];
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_in_s)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            OP_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase

        sa_s = a_signed_s & operand_a[WIDTH-1];
        sb_s = b_signed_s & operand_b[WIDTH-1];

        if (sa_s) a_mag_s = neg_w(operand_a);
        else      a_mag_s = operand_a;
        if (sb_s) b_mag_s = neg_w(operand_b);
        else      b_mag_s = operand_b;

        // Remainder takes the dividend's sign; product and quotient take sa^sb.
        if (op_in_s[2] && op_in_s[1]) neg_in_s = sa_s;
        else                          neg_in_s = sa_s ^ sb_s;

        div_zero_s = op_in_s[2] & (operand_b == ZERO_W);
        div_ovf_s  = op_in_s[2] & ~op_in_s[0] & (operand_a == MIN_NEG) & (operand_b == ALL_ONES);

        // op[1] separates REM/REMU from DIV/DIVU inside the divide group.
        if (div_zero_s) begin
            if (op_in_s[1]) fast_val_s = operand_a;
            else            fast_val_s = ALL_ONES;
        end else begin
            if (op_in_s[1]) fast_val_s = ZERO_W;
            else            fast_val_s = MIN_NEG;
        end
    end

    // Shared adder: trial subtract of the divisor, or conditional add of the multiplicand.
    always_comb begin
        if (op_r[2]) begin
            add_a_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
            add_b_s = ~{1'b0, opnd_r};
            add_c_s = 1'b1;
        end else begin
            add_a_s = {1'b0, acc_hi_r};
            if (acc_lo_r[0]) add_b_s = {1'b0, opnd_r};
            else             add_b_s = ZERO_W1;
            add_c_s = 1'b0;
        end
        sum_s = add_a_s + add_b_s + {{WIDTH{1'b0}}, add_c_s};
    end

    // Sign-correct the raw engine outputs and pick the field for the latched op.
    always_comb begin
        if (neg_r) begin
            prod_fix_s = neg_2w({acc_hi_r, acc_lo_r});
            quo_fix_s  = neg_w(acc_lo_r);
            rem_fix_s  = neg_w(acc_hi_r);
        end else begin
            prod_fix_s = {acc_hi_r, acc_lo_r};
            quo_fix_s  = acc_lo_r;
            rem_fix_s  = acc_hi_r;
        end
        case (op_r)
            OP_MUL:                       fin_val_s = prod_fix_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_val_s = prod_fix_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fin_val_s = quo_fix_s;
            OP_REM, OP_REMU:              fin_val_s = rem_fix_s;
            default:                      fin_val_s = ZERO_W;
        endcase
    end

    // Next-state and datapath update for IDLE -> CALC/FIN -> IDLE.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        opnd_s   = opnd_r;
        acc_hi_s = acc_hi_r;
        acc_lo_s = acc_lo_r;
        count_s  = count_r;
        neg_s    = neg_r;
        fast_s   = fast_r;
        result_s = result_r;
        done_s   = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    op_s     = op_in_s;
                    neg_s    = neg_in_s;
                    count_s  = CNT_LOAD;
                    acc_hi_s = ZERO_W;
                    if (div_zero_s || div_ovf_s) begin
                        fast_s   = 1'b1;
                        acc_lo_s = fast_val_s;
                        opnd_s   = ZERO_W;
                        state_s  = S_FIN;
                    end else begin
                        fast_s  = 1'b0;
                        state_s = S_CALC;
                        // Multiplier/dividend shift through acc_lo; the other operand stays put.
                        if (op_in_s[2]) begin
                            acc_lo_s = a_mag_s;
                            opnd_s   = b_mag_s;
                        end else begin
                            acc_lo_s = b_mag_s;
                            opnd_s   = a_mag_s;
                        end
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_CALC: begin
                count_s = count_r - CNT_ONE;
                if (op_r[2]) begin
                    // Non-negative trial difference means the quotient bit is 1.
                    if (!sum_s[WIDTH]) begin
                        acc_hi_s = sum_s[WIDTH-1:0];
                        acc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_s = add_a_s[WIDTH-1:0];
                        acc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift the carry-extended accumulator right by one.
                    acc_hi_s = sum_s[WIDTH:1];
                    acc_lo_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
                end
                if (count_r == CNT_ONE) state_s = S_FIN;
                else                    state_s = S_CALC;
            end

            S_FIN: begin
                if (fast_r) result_s = acc_lo_r;
                else        result_s = fin_val_s;
                done_s  = 1'b1;
                state_s = S_IDLE;
            end

            default: begin
                state_s = S_IDLE;
            end
        endcase

        busy_s = (state_s != S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= 3'b000;
            opnd_r   <= ZERO_W;
            acc_hi_r <= ZERO_W;
            acc_lo_r <= ZERO_W;
            count_r  <= CNT_ZERO;
            neg_r    <= 1'b0;
            fast_r   <= 1'b0;
            result_r <= ZERO_W;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            op_r     <= op_s;
            opnd_r   <= opnd_s;
            acc_hi_r <= acc_hi_s;
            acc_lo_r <= acc_lo_s;
            count_r  <= count_s;
            neg_r    <= neg_s;
            fast_r   <= fast_s;
            result_r <= result_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit (WIDTH=32). A behavioural model built on
// 64-bit arithmetic predicts result, busy and done every cycle; directed cases
// carry hand-computed results and latencies, then randomized operations run
// back-to-back with stray start pulses while busy.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] last_exp;

    muldiv_unit #(.WIDTH(32), .OP_BITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result straight from the M-extension definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Cycle-level model and the single per-cycle compare against the DUT.
    initial begin : model_compare
        int          m_rem;
        logic        m_done, nd;
        logic [31:0] m_res, m_pend, nr;
        m_rem = 0; m_done = 1'b0; m_res = 32'd0; m_pend = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_rem = 0; m_done = 1'b0; m_res = 32'd0;
            end
            chk("cyc_busy",   busy,   (m_rem > 0));
            chk("cyc_done",   done,   m_done);
            chk("cyc_result", result, m_res);
            if (!rst) begin
                nd = 1'b0;
                nr = m_res;
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        nd = 1'b1;
                        nr = m_pend;
                    end
                end else if (start) begin
                    m_pend = ref_result(op, operand_a, operand_b);
                    m_rem  = is_fast(op, operand_a, operand_b) ? 1 : 33;
                end
                m_done = nd;
                m_res  = nr;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("idle_wait", busy, 1'b0);
    endtask

    // Present one request for exactly one edge, then scramble the inputs.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    endtask

    // Wait for done (bounded), optionally poking start while busy, then check.
    task automatic finish_check(input string nm, input logic [31:0] exp_r, input int exp_lat,
                                input int p_cyc, input logic [2:0] p_op,
                                input logic [31:0] p_a, input logic [31:0] p_b);
        int lat, bcnt;
        bit hold_bad;
        lat = 0; bcnt = 0; hold_bad = 1'b0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            if (result !== last_exp) hold_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (lat == p_cyc) begin
                start = 1'b1; op = p_op; operand_a = p_a; operand_b = p_b;
            end else begin
                start = 1'b0; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_busycyc"}, 64'(bcnt), 64'(exp_lat));
        chk({nm, "_result"}, result, exp_r);
        chk({nm, "_busy_at_done"}, busy, 1'b0);
        chk({nm, "_hold"}, hold_bad, 1'b0);
        last_exp = exp_r;
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        wait_idle();
        launch(o, a, b);
        finish_check(nm, exp_r, exp_lat, -1, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit seen_done;
        rst = 1'b1; start = 1'b0; op = 3'd0; operand_a = 32'd0; operand_b = 32'd0;
        last_exp = 32'd0;

        // Pin the model with hand-computed values.
        chk("pin_mul",    ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("pin_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("pin_div",    ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem",    ref_result(3'd6, 32'd7, 32'hFFFF_FFFE), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Multiply group.
        run("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        // Divide group.
        run("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run("divu",   3'd5, 32'd100,        32'd7,         32'd14,        33);
        run("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33);
        run("rem_nb", 3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33);
        // Fast paths.
        run("div0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         1);
        run("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Start while busy is ignored.
        wait_idle();
        launch(3'd0, 32'd3, 32'd4);
        finish_check("ignored", 32'd12, 33, 10, 3'd5, 32'd9, 32'd3);

        // Reset in the middle of a divide discards it.
        wait_idle();
        launch(3'd4, 32'd100, 32'd7);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_exp = 32'd0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        chk("midrst_no_done", seen_done, 1'b0);
        run("divu_after_rst", 3'd5, 32'd9, 32'd3, 32'd3, 33);

        // Back-to-back issue in the done cycle; the first result must hold.
        run("b2b_first", 3'd0, 32'd5, 32'd6, 32'd30, 33);
        launch(3'd3, 32'd2, 32'd3);
        finish_check("b2b_second", 32'd0, 33, -1, 3'd0, 32'd0, 32'd0);

        // Randomized operations with gaps and stray start pulses.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            int          el, pc;
            o  = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            el = is_fast(o, a, b) ? 1 : 33;
            pc = (el > 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, el - 2)) : -1;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            wait_idle();
            launch(o, a, b);
            finish_check("rnd", ref_result(o, a, b), el, pc, 3'($urandom), $urandom, $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
